test_checker: RTL and testbench
===============================

TEST_CHECKER -- requirements
Module: test_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each compared value.
REQ-002 Parameter CHANNELS, default 2: number of independent compare ports.
REQ-003 Parameter NUM_TESTS, default 16: compare count required for a pass.
REQ-004 Parameter COUNT_W, default 16: width of all counters.
REQ-005 Parameter TIMEOUT_CYCLES, default 50000: RUN-state cycle limit; 0 disables the timeout.
REQ-006 Parameter STOP_ON_FAIL, default 0: 1 ends the run on the first mismatch.
REQ-007 One clock, clk; reset is resetn, asynchronous, active-low.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 resetn  input  1  async active-low reset.
REQ-010 start  input  1  begin/restart a run.
REQ-011 done  input  1  test sequence complete (all_tests_completed equivalent).
REQ-012 chk_valid  input  CHANNELS  per-channel compare request.
REQ-013 chk_expected  input  CHANNELS*DATA_WIDTH  packed expected values, channel 0 in LSBs.
REQ-014 chk_measured  input  CHANNELS*DATA_WIDTH  packed measured values.
REQ-015 chk_mask  input  CHANNELS*DATA_WIDTH  bit compare enables; 1 = compare.
REQ-016 chk_ready  output  1  high only in RUN.
REQ-017 state  output  2  IDLE=0, RUN=1, PASS=2, FAIL=3.
REQ-018 test_passed / test_failed  output  1 each  verdict levels.
REQ-019 test_count / fail_count  output  COUNT_W each  accepted compares / mismatches.
REQ-020 fail_cause  output  2  0 none, 1 mismatch, 2 wrong count, 3 timeout.
REQ-021 first_fail_test  output  COUNT_W; first_fail_chan  output  $clog2(CHANNELS) (min 1); first_fail_exp / first_fail_meas  output  DATA_WIDTH each.

Function
REQ-022 All outputs registered except chk_ready (decoded from state).
REQ-023 IDLE: start -> RUN next cycle; counters, cycle timer, fail_cause and first_fail_* cleared on that edge.
REQ-024 PASS/FAIL: terminal until start; start -> RUN with the same clearing; start in RUN ignored.
REQ-025 A compare is accepted on channel i when chk_valid[i] and chk_ready; valid outside RUN ignored, no counter change.
REQ-026 Mismatch on channel i: (expected_i & mask_i) != (measured_i & mask_i); all-zero mask always matches.
REQ-027 Per cycle, test_count += accepted count, fail_count += mismatch count, both saturating at 2^COUNT_W-1.
REQ-028 First mismatch of a run (fail_count==0 pre-cycle): capture lowest mismatching channel index, its masked expected/measured, first_fail_test = test_count pre-update; later mismatches do not overwrite.
REQ-029 STOP_ON_FAIL=1: mismatch cycle -> FAIL next edge, fail_cause=1; counters include that cycle's compares.
REQ-030 done in RUN: counts and mismatches from the same cycle included; fail_count==0 and test_count==NUM_TESTS -> PASS; else FAIL with cause 1 if fail_count>0, else 2.
REQ-031 Cycle timer counts RUN cycles; reaching TIMEOUT_CYCLES with no done -> FAIL, cause=3.
REQ-032 Same-cycle priority: mismatch (cause 1) > done evaluation > timeout.
REQ-033 test_passed = (state==PASS), test_failed = (state==FAIL), updated on the transition edge; never both high.
REQ-034 Latency: compare to counter update and verdict to state/flags both 1 cycle.

Reset
REQ-035 resetn low asynchronously forces state=IDLE and every registered output to 0; chk_ready=0.
REQ-036 Reset mid-run discards all results; after release the block waits in IDLE for start.

Verification
REQ-037 NUM_TESTS=4, start, 4 single-channel matching compares (0x1234 vs 0x1234), done -> state=PASS, test_passed=1, test_count=4, fail_count=0.
REQ-038 Both channels valid same cycle, ch0 match, ch1 exp 0xA5 meas 0xA4 mask 0xFF, STOP_ON_FAIL=0 -> test_count+=2, fail_count=1, first_fail_chan=1, first_fail_exp=0xA5, first_fail_meas=0xA4; later done -> FAIL, cause=1.
REQ-039 exp 0xF0, meas 0xFF, mask 0xF0 -> counted as match; NUM_TESTS=1, done -> PASS.
REQ-040 NUM_TESTS=4, 3 compares then done -> FAIL, fail_cause=2, test_count=3.
REQ-041 TIMEOUT_CYCLES=20, start, no done -> FAIL exactly 20 RUN cycles after entry, fail_cause=3; start -> RUN with all counters 0.
REQ-042 resetn low mid-RUN with test_count=2 -> immediate IDLE, all outputs 0; chk_valid asserted before start changes nothing.

Source files
------------

// File: rtl/test_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// test_checker : multi-channel masked compare scoreboard with pass/fail verdict
// Rev 1.0
// ---------------------------------------------------------------------------
module test_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int CHANNELS       = 2,
  parameter int NUM_TESTS      = 16,
  parameter int COUNT_W        = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int STOP_ON_FAIL   = 0,
  localparam int CHAN_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           done,
  input  logic [CHANNELS-1:0]            chk_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] chk_expected,
  input  logic [CHANNELS*DATA_WIDTH-1:0] chk_measured,
  input  logic [CHANNELS*DATA_WIDTH-1:0] chk_mask,
  output logic                           chk_ready,
  output logic [1:0]                     state,
  output logic                           test_passed,
  output logic                           test_failed,
  output logic [COUNT_W-1:0]             test_count,
  output logic [COUNT_W-1:0]             fail_count,
  output logic [1:0]                     fail_cause,
  output logic [COUNT_W-1:0]             first_fail_test,
  output logic [CHAN_W-1:0]              first_fail_chan,
  output logic [DATA_WIDTH-1:0]          first_fail_exp,
  output logic [DATA_WIDTH-1:0]          first_fail_meas
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISMATCH = 2'd1;
  localparam logic [1:0] CAUSE_COUNT    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  localparam int ACC_W = $clog2(CHANNELS + 1);
  localparam int SUM_W = COUNT_W + ACC_W;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [COUNT_W-1:0] CNT_MAX     = {COUNT_W{1'b1}};
  localparam logic [SUM_W-1:0]   SUM_MAX     = {{ACC_W{1'b0}}, {COUNT_W{1'b1}}};
  localparam logic [COUNT_W-1:0] NUM_TESTS_C = COUNT_W'(NUM_TESTS);
  localparam logic [TMR_W-1:0]   TMR_LAST    =
    TMR_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t                  state_q, state_d;
  logic                    test_passed_q, test_passed_d;
  logic                    test_failed_q, test_failed_d;
  logic [COUNT_W-1:0]      test_count_q, test_count_d;
  logic [COUNT_W-1:0]      fail_count_q, fail_count_d;
  logic [1:0]              fail_cause_q, fail_cause_d;
  logic [COUNT_W-1:0]      ff_test_q, ff_test_d;
  logic [CHAN_W-1:0]       ff_chan_q, ff_chan_d;
  logic [DATA_WIDTH-1:0]   ff_exp_q, ff_exp_d;
  logic [DATA_WIDTH-1:0]   ff_meas_q, ff_meas_d;
  logic [TMR_W-1:0]        timer_q, timer_d;

  logic                    run;
  logic [ACC_W-1:0]        acc_cnt;
  logic [ACC_W-1:0]        mis_cnt;
  logic                    mis_any;
  logic [CHAN_W-1:0]       mis_chan;
  logic [DATA_WIDTH-1:0]   mis_exp;
  logic [DATA_WIDTH-1:0]   mis_meas;
  logic [DATA_WIDTH-1:0]   exp_m;
  logic [DATA_WIDTH-1:0]   meas_m;
  logic [SUM_W-1:0]        test_sum;
  logic [SUM_W-1:0]        fail_sum;
  logic [COUNT_W-1:0]      test_sat;
  logic [COUNT_W-1:0]      fail_sat;

  assign run = (state_q == ST_RUN);

  // Descending scan so the lowest mismatching channel is the one left captured.
  always_comb begin
    acc_cnt  = '0;
    mis_cnt  = '0;
    mis_any  = 1'b0;
    mis_chan = '0;
    mis_exp  = '0;
    mis_meas = '0;
    exp_m    = '0;
    meas_m   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      exp_m  = chk_expected[i*DATA_WIDTH +: DATA_WIDTH] & chk_mask[i*DATA_WIDTH +: DATA_WIDTH];
      meas_m = chk_measured[i*DATA_WIDTH +: DATA_WIDTH] & chk_mask[i*DATA_WIDTH +: DATA_WIDTH];
      if (run && chk_valid[i]) begin
        acc_cnt = acc_cnt + ACC_W'(1);
        if (exp_m != meas_m) begin
          mis_cnt  = mis_cnt + ACC_W'(1);
          mis_any  = 1'b1;
          mis_chan = CHAN_W'(i);
          mis_exp  = exp_m;
          mis_meas = meas_m;
        end
      end
    end
  end

  always_comb begin
    test_sum = SUM_W'(test_count_q) + SUM_W'(acc_cnt);
    fail_sum = SUM_W'(fail_count_q) + SUM_W'(mis_cnt);
    test_sat = (test_sum > SUM_MAX) ? CNT_MAX : test_sum[COUNT_W-1:0];
    fail_sat = (fail_sum > SUM_MAX) ? CNT_MAX : fail_sum[COUNT_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    test_count_d = test_count_q;
    fail_count_d = fail_count_q;
    fail_cause_d = fail_cause_q;
    ff_test_d    = ff_test_q;
    ff_chan_d    = ff_chan_q;
    ff_exp_d     = ff_exp_q;
    ff_meas_d    = ff_meas_q;
    timer_d      = timer_q;

    case (state_q)
      ST_RUN: begin
        test_count_d = test_sat;
        fail_count_d = fail_sat;
        if (TIMEOUT_CYCLES > 0) begin
          timer_d = timer_q + TMR_W'(1);
        end
        if (mis_any && (fail_count_q == '0)) begin
          ff_test_d = test_count_q;
          ff_chan_d = mis_chan;
          ff_exp_d  = mis_exp;
          ff_meas_d = mis_meas;
        end
        // Mismatch stop outranks done, which outranks the timeout.
        if ((STOP_ON_FAIL != 0) && mis_any) begin
          state_d      = ST_FAIL;
          fail_cause_d = CAUSE_MISMATCH;
        end else if (done) begin
          if (fail_sat != '0) begin
            state_d      = ST_FAIL;
            fail_cause_d = CAUSE_MISMATCH;
          end else if (test_sat == NUM_TESTS_C) begin
            state_d      = ST_PASS;
            fail_cause_d = CAUSE_NONE;
          end else begin
            state_d      = ST_FAIL;
            fail_cause_d = CAUSE_COUNT;
          end
        end else if ((TIMEOUT_CYCLES > 0) && (timer_q == TMR_LAST)) begin
          state_d      = ST_FAIL;
          fail_cause_d = CAUSE_TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          state_d      = ST_RUN;
          test_count_d = '0;
          fail_count_d = '0;
          fail_cause_d = CAUSE_NONE;
          ff_test_d    = '0;
          ff_chan_d    = '0;
          ff_exp_d     = '0;
          ff_meas_d    = '0;
          timer_d      = '0;
        end
      end
    endcase

    test_passed_d = (state_d == ST_PASS);
    test_failed_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      test_passed_q <= 1'b0;
      test_failed_q <= 1'b0;
      test_count_q  <= '0;
      fail_count_q  <= '0;
      fail_cause_q  <= CAUSE_NONE;
      ff_test_q     <= '0;
      ff_chan_q     <= '0;
      ff_exp_q      <= '0;
      ff_meas_q     <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      test_passed_q <= test_passed_d;
      test_failed_q <= test_failed_d;
      test_count_q  <= test_count_d;
      fail_count_q  <= fail_count_d;
      fail_cause_q  <= fail_cause_d;
      ff_test_q     <= ff_test_d;
      ff_chan_q     <= ff_chan_d;
      ff_exp_q      <= ff_exp_d;
      ff_meas_q     <= ff_meas_d;
      timer_q       <= timer_d;
    end
  end

  assign chk_ready       = run;
  assign state           = state_q;
  assign test_passed     = test_passed_q;
  assign test_failed     = test_failed_q;
  assign test_count      = test_count_q;
  assign fail_count      = fail_count_q;
  assign fail_cause      = fail_cause_q;
  assign first_fail_test = ff_test_q;
  assign first_fail_chan = ff_chan_q;
  assign first_fail_exp  = ff_exp_q;
  assign first_fail_meas = ff_meas_q;

endmodule
`default_nettype wire

// File: tb/tb_test_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_test_checker : directed bench for test_checker (two parameter sets)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_test_checker;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        done;
  logic [1:0]  chk_valid;
  logic [63:0] chk_expected;
  logic [63:0] chk_measured;
  logic [63:0] chk_mask;

  // Instance A: NUM_TESTS=4, timeout 20, keep running on mismatch
  logic        a_ready, a_passed, a_failed;
  logic [1:0]  a_state, a_cause;
  logic [15:0] a_tcnt, a_fcnt, a_fftest;
  logic [0:0]  a_ffchan;
  logic [31:0] a_ffexp, a_ffmeas;

  // Instance B: NUM_TESTS=1, 3-bit counters, timeout disabled, stop on mismatch
  logic        b_ready, b_passed, b_failed;
  logic [1:0]  b_state, b_cause;
  logic [2:0]  b_tcnt, b_fcnt, b_fftest;
  logic [0:0]  b_ffchan;
  logic [31:0] b_ffexp, b_ffmeas;

  int n_tests = 0;
  int n_fail  = 0;

  test_checker #(
    .DATA_WIDTH(32), .CHANNELS(2), .NUM_TESTS(4), .COUNT_W(16),
    .TIMEOUT_CYCLES(20), .STOP_ON_FAIL(0)
  ) u_dut_a (
    .clk(clk), .resetn(resetn), .start(start), .done(done),
    .chk_valid(chk_valid), .chk_expected(chk_expected),
    .chk_measured(chk_measured), .chk_mask(chk_mask),
    .chk_ready(a_ready), .state(a_state),
    .test_passed(a_passed), .test_failed(a_failed),
    .test_count(a_tcnt), .fail_count(a_fcnt), .fail_cause(a_cause),
    .first_fail_test(a_fftest), .first_fail_chan(a_ffchan),
    .first_fail_exp(a_ffexp), .first_fail_meas(a_ffmeas)
  );

  test_checker #(
    .DATA_WIDTH(32), .CHANNELS(2), .NUM_TESTS(1), .COUNT_W(3),
    .TIMEOUT_CYCLES(0), .STOP_ON_FAIL(1)
  ) u_dut_b (
    .clk(clk), .resetn(resetn), .start(start), .done(done),
    .chk_valid(chk_valid), .chk_expected(chk_expected),
    .chk_measured(chk_measured), .chk_mask(chk_mask),
    .chk_ready(b_ready), .state(b_state),
    .test_passed(b_passed), .test_failed(b_failed),
    .test_count(b_tcnt), .fail_count(b_fcnt), .fail_cause(b_cause),
    .first_fail_test(b_fftest), .first_fail_chan(b_ffchan),
    .first_fail_exp(b_ffexp), .first_fail_meas(b_ffmeas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cycle();
    done = 1'b0;
  endtask

  task automatic cmp(input logic [1:0] v,
                     input logic [31:0] e0, input logic [31:0] m0, input logic [31:0] k0,
                     input logic [31:0] e1, input logic [31:0] m1, input logic [31:0] k1);
    chk_valid    = v;
    chk_expected = {e1, e0};
    chk_measured = {m1, m0};
    chk_mask     = {k1, k0};
    cycle();
    chk_valid = 2'b00;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; done = 1'b0;
    chk_valid = '0; chk_expected = '0; chk_measured = '0; chk_mask = '0;

    // Reset state
    cycle(); cycle();
    check("rst_state", a_state, 2'd0);
    check("rst_ready", a_ready, 1'b0);
    check("rst_flags", {a_passed, a_failed}, 2'b00);
    check("rst_counts", {a_tcnt, a_fcnt}, 32'd0);
    resetn = 1'b1;
    cycle();

    // Valid with no run in progress is ignored
    cmp(2'b11, 32'h1, 32'h2, 32'hF, 32'h3, 32'h4, 32'hF);
    cmp(2'b01, 32'h1, 32'h2, 32'hF, 32'h0, 32'h0, 32'h0);
    check("idle_valid_state", a_state, 2'd0);
    check("idle_valid_counts", {a_tcnt, a_fcnt}, 32'd0);

    // Four matching compares then done
    pulse_start();
    check("start_run", a_state, 2'd1);
    check("run_ready", a_ready, 1'b1);
    cmp(2'b01, 32'h1234, 32'h1234, 32'hFFFF_FFFF, 0, 0, 0);
    check("cnt_latency", a_tcnt, 16'd1);
    for (int i = 0; i < 3; i++) cmp(2'b01, 32'h1234, 32'h1234, 32'hFFFF_FFFF, 0, 0, 0);
    check("four_cnt", a_tcnt, 16'd4);
    pulse_done();
    check("pass_state", a_state, 2'd2);
    check("pass_flags", {a_passed, a_failed}, 2'b10);
    check("pass_counts", {a_tcnt, a_fcnt}, {16'd4, 16'd0});
    check("pass_cause", a_cause, 2'd0);
    check("b_wrongcnt", {b_state, b_cause, b_tcnt}, {2'd3, 2'd2, 3'd4});

    // Two-channel cycle, channel 1 mismatches
    pulse_start();
    check("restart_clr", {a_state, a_tcnt}, {2'd1, 16'd0});
    cmp(2'b11, 32'h55, 32'h55, 32'hFF, 32'hA5, 32'hA4, 32'hFF);
    check("mm_counts", {a_tcnt, a_fcnt}, {16'd2, 16'd1});
    check("mm_chan", a_ffchan, 1'b1);
    check("mm_exp_meas", {a_ffexp, a_ffmeas}, {32'hA5, 32'hA4});
    check("mm_fftest", a_fftest, 16'd0);
    check("mm_still_run", a_state, 2'd1);
    check("b_stop", {b_state, b_cause, b_failed}, {2'd3, 2'd1, 1'b1});
    check("b_stop_counts", {b_tcnt, b_fcnt, b_ffchan}, {3'd2, 3'd1, 1'b1});
    cmp(2'b01, 32'h1, 32'h2, 32'hF, 0, 0, 0);
    check("mm2_counts", {a_tcnt, a_fcnt}, {16'd3, 16'd2});
    check("mm2_keep_first", {a_ffchan, a_ffexp, a_fftest}, {1'b1, 32'hA5, 16'd0});
    check("b_frozen", b_tcnt, 3'd2);
    pulse_done();
    check("mm_verdict", {a_state, a_cause}, {2'd3, 2'd1});
    check("mm_flags", {a_passed, a_failed}, 2'b01);

    // Masked compares: only masked bits matter, all-zero mask always matches
    pulse_start();
    check("ff_cleared", {a_ffexp, a_ffmeas, a_cause}, 66'd0);
    cmp(2'b10, 0, 0, 0, 32'hF0, 32'hFF, 32'hF0);
    cmp(2'b01, 32'hDEAD, 32'hBEEF, 32'h0, 0, 0, 0);
    cmp(2'b10, 0, 0, 0, 32'hF0, 32'hFF, 32'hF0);
    cmp(2'b01, 32'hDEAD, 32'hBEEF, 32'h0, 0, 0, 0);
    pulse_done();
    check("mask_pass", {a_state, a_tcnt, a_fcnt}, {2'd2, 16'd4, 16'd0});

    // Single masked compare: B passes, A is short on count
    pulse_start();
    cmp(2'b10, 0, 0, 0, 32'hF0, 32'hFF, 32'hF0);
    pulse_done();
    check("b_single_pass", {b_state, b_passed, b_failed}, {2'd2, 1'b1, 1'b0});
    check("a_short1", {a_state, a_cause, a_tcnt}, {2'd3, 2'd2, 16'd1});

    // Three compares, done in the same cycle as the third
    pulse_start();
    cmp(2'b01, 32'h7, 32'h7, 32'hF, 0, 0, 0);
    cmp(2'b01, 32'h7, 32'h7, 32'hF, 0, 0, 0);
    done = 1'b1;
    cmp(2'b01, 32'h7, 32'h7, 32'hF, 0, 0, 0);
    done = 1'b0;
    check("a_short3", {a_state, a_cause, a_tcnt, a_fcnt}, {2'd3, 2'd2, 16'd3, 16'd0});

    // Timeout: FAIL exactly 20 RUN cycles after entry
    pulse_start();
    for (int i = 0; i < 19; i++) cycle();
    check("to_before", a_state, 2'd1);
    cycle();
    check("to_fail", {a_state, a_cause, a_failed}, {2'd3, 2'd3, 1'b1});
    check("b_no_timeout", b_state, 2'd1);
    pulse_start();
    check("to_restart", {a_state, a_cause, a_tcnt, a_fcnt}, {2'd1, 2'd0, 16'd0, 16'd0});

    // Five two-channel matching cycles: B's 3-bit counter saturates
    for (int i = 0; i < 5; i++) cmp(2'b11, 32'h9, 32'h9, 32'hF, 32'h6, 32'h6, 32'hF);
    check("a_cnt10", a_tcnt, 16'd10);
    check("b_sat", {b_state, b_tcnt, b_fcnt}, {2'd1, 3'd7, 3'd0});

    // Asynchronous reset mid-run
    #2 resetn = 1'b0;
    #1;
    check("arst_state", {a_state, b_state}, 4'd0);
    check("arst_ready", {a_ready, b_ready}, 2'b00);
    check("arst_counts", {a_tcnt, a_fcnt, a_passed, a_failed, a_cause}, 36'd0);
    cycle();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) cmp(2'b11, 32'h1, 32'h2, 32'hF, 32'h3, 32'h3, 32'hF);
    check("post_rst_idle", {a_state, a_tcnt, a_fcnt}, {2'd0, 16'd0, 16'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
